// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: source IDs,
// default requester count and common constants.
package rf_wb_arbiter_pkg;

  localparam int unsigned NREQ_DEFAULT = 3;

  localparam logic [1:0] SRC_ALU    = 2'd0;
  localparam logic [1:0] SRC_LOAD   = 2'd1;
  localparam logic [1:0] SRC_MULDIV = 2'd2;

  localparam logic        RstEnable  = 1'b1;
  localparam logic [31:0] Zero       = 32'h0000_0000;
  localparam logic        WbWrEnable = 1'b1;

  // Number of asserted bits in a request vector, wide enough for any sane NREQ
  function automatic logic [7:0] popcount8(input logic [7:0] v);
    logic [7:0] cnt;
    cnt = 8'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {7'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first asserted request scanning
// ptr, ptr+1, ... modulo N wins; outputs one-hot grant plus its index.
module rr_arbiter #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand_s;
  logic          found_s;

  // Rotating priority scan starting at ptr
  always_comb begin
    gnt     = {N{1'b0}};
    idx     = {IW{1'b0}};
    cand_s  = {IW{1'b0}};
    found_s = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      cand_s = IW'((int'(ptr) + k) % int'(N));
      if (!found_s && req[cand_s]) begin
        found_s     = 1'b1;
        gnt[cand_s] = 1'b1;
        idx         = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the single register-file write port among the writeback sources
// with round-robin valid/ready arbitration and a registered write stage.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32,
  parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic               rf_we,
  output logic [AW-1:0]      rf_waddr,
  output logic [DW-1:0]      rf_wdata,
  output logic [IW-1:0]      grant_id,
  output logic [15:0]        conflict_cnt
);

  logic [IW-1:0]   ptr_r;
  logic [NREQ-1:0] gnt_s;
  logic [IW-1:0]   idx_s;
  logic            xfer_s;
  logic [AW-1:0]   sel_addr_s;
  logic [DW-1:0]   sel_data_s;
  logic [7:0]      nvalid_s;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
    .req (req_valid),
    .ptr (ptr_r),
    .gnt (gnt_s),
    .idx (idx_s)
  );

  // Ready is suppressed during reset so nothing can transfer
  always_comb begin
    req_ready = {NREQ{1'b0}};
    if (rst == RstEnable) begin
      req_ready = {NREQ{1'b0}};
    end else begin
      req_ready = gnt_s;
    end
  end

  assign xfer_s = |req_ready;

  // Select the winner's address and data
  always_comb begin
    sel_addr_s = {AW{1'b0}};
    sel_data_s = {DW{1'b0}};
    for (int i = 0; i < int'(NREQ); i++) begin
      if (idx_s == IW'(i)) begin
        sel_addr_s = req_addr[i*AW +: AW];
        sel_data_s = req_data[i*DW +: DW];
      end else begin
        sel_addr_s = sel_addr_s;
      end
    end
  end

  always_comb begin
    nvalid_s = popcount8(8'(req_valid));
  end

  // Priority pointer moves past the winner only when a transfer happens
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      ptr_r <= {IW{1'b0}};
    end else if (xfer_s) begin
      if (idx_s == IW'(NREQ - 1)) begin
        ptr_r <= {IW{1'b0}};
      end else begin
        ptr_r <= idx_s + IW'(1);
      end
    end
  end

  // Output write stage; writes to r0 are accepted but never enabled
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      rf_we    <= 1'b0;
      rf_waddr <= {AW{1'b0}};
      rf_wdata <= {DW{1'b0}};
      grant_id <= {IW{1'b0}};
    end else if (xfer_s) begin
      rf_we    <= (sel_addr_s != {AW{1'b0}}) ? WbWrEnable : 1'b0;
      rf_waddr <= sel_addr_s;
      rf_wdata <= sel_data_s;
      grant_id <= idx_s;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Saturating count of contended cycles
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      conflict_cnt <= 16'h0000;
    end else if ((nvalid_s >= 8'd2) && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with hand-computed expectations.
module tb_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               rf_we;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;
  logic [1:0]         grant_id;
  logic [15:0]        conflict_cnt;

  logic [DW-1:0] rf_model [0:31];
  int total_cnt;
  int bad_cnt;

  rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .grant_id     (grant_id),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file as seen by the pipeline
  always @(posedge clk) begin
    if (rf_we) rf_model[rf_waddr] <= rf_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst       = 1'b1;
    req_valid = 3'b111;
    req_addr  = '0;
    req_data  = '0;
    #1;
    chk("ready_in_rst", 64'(req_ready), 64'h0);
    step();
    req_valid = 3'b000;
    step();
    rst = 1'b0;
    step();
    chk("rst_we", 64'(rf_we), 64'h0);
    chk("rst_waddr", 64'(rf_waddr), 64'h0);
    chk("rst_wdata", 64'(rf_wdata), 64'h0);
    chk("rst_gid", 64'(grant_id), 64'h0);
    chk("rst_cnt", 64'(conflict_cnt), 64'h0);

    // single ALU write r3 = AA
    set_req(0, 5'd3, 32'h0000_00AA);
    req_valid = 3'b001;
    #1;
    chk("alu_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = 3'b000;
    chk("alu_we", 64'(rf_we), 64'h1);
    chk("alu_waddr", 64'(rf_waddr), 64'h3);
    chk("alu_wdata", 64'(rf_wdata), 64'hAA);
    chk("alu_gid", 64'(grant_id), 64'h0);
    step();
    chk("alu_we_drop", 64'(rf_we), 64'h0);

    // reset to ptr=0, then all three contend
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 5'd1, 32'h0000_0101);
    set_req(1, 5'd2, 32'h0000_0202);
    set_req(2, 5'd4, 32'h0000_0404);
    req_valid = 3'b111;
    #1;
    chk("rr_ready0", 64'(req_ready), 64'h1);
    step();
    chk("rr_gid0", 64'(grant_id), 64'h0);
    chk("rr_waddr0", 64'(rf_waddr), 64'h1);
    chk("rr_we0", 64'(rf_we), 64'h1);
    req_valid = 3'b110;
    #1;
    chk("rr_ready1", 64'(req_ready), 64'h2);
    step();
    chk("rr_gid1", 64'(grant_id), 64'h1);
    chk("rr_wdata1", 64'(rf_wdata), 64'h202);
    chk("rr_we1", 64'(rf_we), 64'h1);
    req_valid = 3'b100;
    #1;
    chk("rr_ready2", 64'(req_ready), 64'h4);
    step();
    req_valid = 3'b000;
    chk("rr_gid2", 64'(grant_id), 64'h2);
    chk("rr_waddr2", 64'(rf_waddr), 64'h4);
    chk("rr_we2", 64'(rf_we), 64'h1);
    chk("rr_cnt", 64'(conflict_cnt), 64'h2);
    step();
    chk("rr_we_drop", 64'(rf_we), 64'h0);

    // LOAD write to r0 with ptr=0: accepted, no write, ptr moves to 2
    set_req(1, 5'd0, 32'hDEAD_BEEF);
    req_valid = 3'b010;
    #1;
    chk("r0_ready", 64'(req_ready), 64'h2);
    step();
    chk("r0_we", 64'(rf_we), 64'h0);
    chk("r0_gid", 64'(grant_id), 64'h1);
    chk("r0_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    set_req(0, 5'd9, 32'h0000_0009);
    set_req(2, 5'd10, 32'h0000_0010);
    req_valid = 3'b101;
    #1;
    chk("r0_rot_ready", 64'(req_ready), 64'h4);
    step();
    req_valid = 3'b000;
    chk("r0_rot_gid", 64'(grant_id), 64'h2);
    chk("r0_rot_cnt", 64'(conflict_cnt), 64'h3);
    step();

    // same destination r7 from ALU and MULDIV with ptr=0
    set_req(0, 5'd7, 32'h0000_0011);
    set_req(2, 5'd7, 32'h0000_0022);
    req_valid = 3'b101;
    #1;
    chk("same_ready0", 64'(req_ready), 64'h1);
    step();
    chk("same_wdata0", 64'(rf_wdata), 64'h11);
    req_valid = 3'b100;
    step();
    req_valid = 3'b000;
    chk("same_wdata1", 64'(rf_wdata), 64'h22);
    chk("same_gid1", 64'(grant_id), 64'h2);
    step();
    chk("same_final_r7", 64'(rf_model[7]), 64'h22);

    // reset while a write is held in the output register
    set_req(0, 5'd5, 32'h0000_0055);
    req_valid = 3'b011;
    step();
    chk("mid_pending_we", 64'(rf_we), 64'h1);
    rst = 1'b1;
    #1;
    chk("mid_ready_rst", 64'(req_ready), 64'h0);
    step();
    chk("mid_we", 64'(rf_we), 64'h0);
    chk("mid_waddr", 64'(rf_waddr), 64'h0);
    chk("mid_wdata", 64'(rf_wdata), 64'h0);
    chk("mid_gid", 64'(grant_id), 64'h0);
    chk("mid_cnt", 64'(conflict_cnt), 64'h0);
    req_valid = 3'b000;
    rst = 1'b0;
    step();

    // lone LOAD requester granted every cycle
    set_req(1, 5'd12, 32'h0000_0C0C);
    req_valid = 3'b010;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("lone_ready", 64'(req_ready), 64'h2);
      step();
      chk("lone_we", 64'(rf_we), 64'h1);
    end
    req_valid = 3'b000;
    step();

    // long contention saturates the counter
    req_valid = 3'b011;
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_cnt", 64'(conflict_cnt), 64'hFFFF);
    step();
    chk("sat_hold", 64'(conflict_cnt), 64'hFFFF);
    req_valid = 3'b000;

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
